// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync-region states and colour type.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int BAR_W        = 80;

  typedef enum logic [1:0] {
    ST_ACT,
    ST_FP,
    ST_SYNC,
    ST_BP
  } tstate_t;

  typedef logic [11:0] rgb_t;

endpackage

// File: rtl/vga_bar_pattern.sv
// Eight 80-pixel vertical colour bars, black outside the active area.
module vga_bar_pattern
  import vga_timing_pkg::*;
(
  input  logic [9:0]  x,
  input  logic        de,
  output logic [11:0] rgb
);

  logic [2:0] bar;

  assign bar = 3'(x / 10'(BAR_W));

  always_comb begin
    rgb = '0;
    if (de) begin
      unique case (bar)
        3'd0: rgb = 12'hFFF;
        3'd1: rgb = 12'hFF0;
        3'd2: rgb = 12'h0FF;
        3'd3: rgb = 12'h0F0;
        3'd4: rgb = 12'hF0F;
        3'd5: rgb = 12'hF00;
        3'd6: rgb = 12'h00F;
        3'd7: rgb = 12'h000;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing driven by a pixel strobe in the system clock domain.
// VGA_TEST_PATTERN_EN adds the rgb port with a colour-bar generator.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pix_ce,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] rgb
`endif
);

  localparam logic [9:0] H_E0 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_E1 = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_E2 = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_E3 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_E0 = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_E1 = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_E2 = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_E3 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Leave a region when the counter sits on that region's last value.
  function automatic tstate_t st_next(
    tstate_t    s,
    logic [9:0] c,
    logic [9:0] e0,
    logic [9:0] e1,
    logic [9:0] e2,
    logic [9:0] e3
  );
    tstate_t n;
    n = s;
    unique case (s)
      ST_ACT:  if (c == e0) n = ST_FP;
      ST_FP:   if (c == e1) n = ST_SYNC;
      ST_SYNC: if (c == e2) n = ST_BP;
      ST_BP:   if (c == e3) n = ST_ACT;
    endcase
    return n;
  endfunction

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  tstate_t    h_st_q, h_st_d;
  tstate_t    v_st_q, v_st_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       act;
  logic       h_end;

  assign act   = (h_st_q == ST_ACT) && (v_st_q == ST_ACT);
  assign h_end = (h_cnt_q == H_E3);

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_q, rgb_d, bar_rgb;

  vga_bar_pattern u_bars (
    .x  (h_cnt_q),
    .de (act),
    .rgb(bar_rgb)
  );

  always_comb begin
    rgb_d = rgb_q;
    if (!en)         rgb_d = '0;
    else if (pix_ce) rgb_d = bar_rgb;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rgb_q <= '0;
    else            rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_st_d  = h_st_q;
    v_st_d  = v_st_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    x_d     = x_q;
    y_d     = y_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      h_st_d  = ST_ACT;
      v_st_d  = ST_ACT;
      hsync_d = ~HS_POL;
      vsync_d = ~VS_POL;
      de_d    = 1'b0;
    end else if (pix_ce) begin
      // Outputs describe the position held before this strobe.
      de_d    = act;
      hsync_d = (h_st_q == ST_SYNC) ? HS_POL : ~HS_POL;
      vsync_d = (v_st_q == ST_SYNC) ? VS_POL : ~VS_POL;
      if (act) begin
        x_d = h_cnt_q;
        y_d = v_cnt_q;
      end
      ls_d    = (h_cnt_q == '0);
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
      h_cnt_d = h_end ? '0 : h_cnt_q + 10'd1;
      h_st_d  = st_next(h_st_q, h_cnt_q, H_E0, H_E1, H_E2, H_E3);
      if (h_end) begin
        v_cnt_d = (v_cnt_q == V_E3) ? '0 : v_cnt_q + 10'd1;
        v_st_d  = st_next(v_st_q, v_cnt_q, V_E0, V_E1, V_E2, V_E3);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_st_q  <= ST_ACT;
      v_st_q  <= ST_ACT;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_st_q  <= h_st_d;
      v_st_q  <= v_st_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, short-frame instance
// (10 lines) for vertical timing, frame period and enable restart.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic pix_ce;
  logic en;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] d_rgb, s_rgb;
`endif

  int n_chk;
  int n_fail;
  int cyc;

  vga_timing_gen u_dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .pix_ce     (pix_ce),
    .en         (en),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .de         (d_de),
    .x          (d_x),
    .y          (d_y),
    .line_start (d_ls),
    .frame_start(d_fs)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb        (d_rgb)
`endif
  );

  vga_timing_gen #(
    .V_ACTIVE(4),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (2)
  ) u_small (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .pix_ce     (pix_ce),
    .en         (en),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .de         (s_de),
    .x          (s_x),
    .y          (s_y),
    .line_start (s_ls),
    .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb        (s_rgb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
  endtask

  task automatic pixels(int n, int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      repeat (gap) step(1'b0);
    end
  endtask

  typedef struct {
    int          p;
    logic        hs;
    logic        vs;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vt[12];

  initial begin
    int cur;
    int hs_low, hs_first, de_cnt, x_err;
    int fs_n, fs_idle;
    int fs_p[3];
    int fs_c[3];
    int de0, de1, vs0, vs_first, ymax;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    en     = 1'b1;

    //            p   hs    vs    de    x    y   ls    fs    rgb
    vt[0]  = '{1,   1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b1, 12'hFFF};
    vt[1]  = '{2,   1'b1, 1'b1, 1'b1, 1,   0, 1'b0, 1'b0, 12'hFFF};
    vt[2]  = '{86,  1'b1, 1'b1, 1'b1, 85,  0, 1'b0, 1'b0, 12'hFF0};
    vt[3]  = '{640, 1'b1, 1'b1, 1'b1, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[4]  = '{641, 1'b1, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[5]  = '{656, 1'b1, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[6]  = '{657, 1'b0, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[7]  = '{752, 1'b0, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[8]  = '{753, 1'b1, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[9]  = '{800, 1'b1, 1'b1, 1'b0, 639, 0, 1'b0, 1'b0, 12'h000};
    vt[10] = '{801, 1'b1, 1'b1, 1'b1, 0,   1, 1'b1, 1'b0, 12'hFFF};
    vt[11] = '{802, 1'b1, 1'b1, 1'b1, 1,   1, 1'b0, 1'b0, 12'hFFF};

    repeat (3) step(1'b0);
    chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);
    chk("rst_de", d_de, 0);
    chk("rst_xy", {d_x, d_y}, 0);
    chk("rst_pulses", {d_ls, d_fs}, 0);
    rst_n = 1'b1;
    step(1'b0);

    cur = 0;
    for (int i = 0; i < 12; i++) begin
      pixels(vt[i].p - cur, 0);
      cur = vt[i].p;
      chk($sformatf("v%0d_hsync", i), d_hs, vt[i].hs);
      chk($sformatf("v%0d_vsync", i), d_vs, vt[i].vs);
      chk($sformatf("v%0d_de", i), d_de, vt[i].de);
      chk($sformatf("v%0d_x", i), d_x, vt[i].x);
      chk($sformatf("v%0d_y", i), d_y, vt[i].y);
      chk($sformatf("v%0d_line_start", i), d_ls, vt[i].ls);
      chk($sformatf("v%0d_frame_start", i), d_fs, vt[i].fs);
`ifdef VGA_TEST_PATTERN_EN
      chk($sformatf("v%0d_rgb", i), d_rgb, vt[i].rgb);
`endif
    end

    step(1'b0);
    chk("idle_hold_x", d_x, 1);
    chk("idle_hold_de", d_de, 1);

    // Full line 2: sync width/position, active width, column tracking.
    pixels(798, 0);
    hs_low   = 0;
    hs_first = -1;
    de_cnt   = 0;
    x_err    = 0;
    for (int k = 0; k < 800; k++) begin
      step(1'b1);
      if (d_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (d_de) begin
        de_cnt++;
        if (d_x != 10'(k)) x_err++;
      end
    end
    chk("line_hs_low_px", hs_low, 96);
    chk("line_hs_first_px", hs_first, 656);
    chk("line_de_px", de_cnt, 640);
    chk("line_x_errors", x_err, 0);
    chk("line_y", d_y, 2);

    // Asynchronous reset in the middle of a frame at (300,5).
    pixels(1900, 0);
    chk("mid_de", d_de, 1);
    chk("mid_x", d_x, 299);
    chk("mid_y", d_y, 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_de", d_de, 0);
    chk("async_rst_x", d_x, 0);
    chk("async_rst_y", d_y, 0);
    chk("async_rst_sync", {d_hs, d_vs, s_vs}, 3'b111);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("post_rst_frame_start", d_fs, 1);
    chk("post_rst_small_fs", s_fs, 1);
    step(1'b0);
    chk("post_rst_fs_single", d_fs, 0);
    chk("post_rst_de_hold", d_de, 1);

    // Enable dropped at (700,9) of the short frame for 10 strobes.
    pixels(7899, 0);
    chk("en_pre_hsync", s_hs, 0);
    chk("en_pre_vsync", s_vs, 1);
    en = 1'b0;
    pixels(10, 0);
    chk("en_off_hsync", s_hs, 1);
    chk("en_off_de", s_de, 0);
    chk("en_off_pulses", {s_ls, s_fs}, 0);
    en = 1'b1;
    step(1'b1);
    chk("en_on_frame_start", s_fs, 1);
    chk("en_on_de", s_de, 1);
    chk("en_on_xy", {s_x, s_y}, 0);
    step(1'b1);
    chk("en_on_x1", s_x, 1);
    chk("en_on_fs_single", s_fs, 0);
    pixels(799, 0);
    chk("en_line1_x", s_x, 0);
    chk("en_line1_y", s_y, 1);
    chk("en_line1_ls", s_ls, 1);

    // Two short frames with the strobe on every 4th cycle.
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    fs_n     = 0;
    fs_idle  = 0;
    de0      = 0;
    de1      = 0;
    vs0      = 0;
    vs_first = -1;
    ymax     = 0;
    for (int p = 1; p <= 16001; p++) begin
      step(1'b1);
      if (s_fs) begin
        if (fs_n < 3) begin
          fs_p[fs_n] = p;
          fs_c[fs_n] = cyc;
        end
        fs_n++;
      end
      if (p <= 8000) begin
        if (s_de) de0++;
        if (s_de && int'(s_y) > ymax) ymax = int'(s_y);
        if (s_vs == 1'b0) begin
          vs0++;
          if (vs_first < 0) vs_first = p;
        end
      end else if (p <= 16000) begin
        if (s_de) de1++;
      end
      if (p == 3040) chk("last_act_px", {s_de, s_x, s_y}, {1'b1, 10'd639, 10'd3});
      if (p == 3041) chk("first_blank_px", {s_de, s_y}, {1'b0, 10'd3});
      for (int g = 0; g < 3; g++) begin
        step(1'b0);
        if (s_fs || s_ls) fs_idle++;
      end
    end
    chk("fs_count", fs_n, 3);
    chk("pix_per_frame", fs_p[1] - fs_p[0], 8000);
    chk("fs_period0", fs_c[1] - fs_c[0], 32000);
    chk("fs_period1", fs_c[2] - fs_c[1], 32000);
    chk("fs_idle_pulses", fs_idle, 0);
    chk("frame0_de_px", de0, 2560);
    chk("frame1_de_px", de1, 2560);
    chk("frame_vs_low_px", vs0, 1600);
    chk("frame_vs_first_px", vs_first, 4801);
    chk("frame_ymax", ymax, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
